// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes the rx line, recovers frames by mid-bit sampling
// and delivers bytes on a valid/ready handshake with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_deliver;
    logic             w_ferr;

    // Two-flop synchronizer plus one flop of edge history; idle-high after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic: mid-bit sampling, LSB shifted in first from the top.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rx_s && r_rx_prev) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_BREAK: begin
                // A held-low line must go high before another start edge is accepted.
                w_cnt_nxt = '0;
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BREAK;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_bit_nxt   = 3'd0;
            end
        endcase
    end

    // Output handshake: load on delivery when the slot is free or being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written sequences
// for back-to-back, glitch, framing error, overrun and mid-frame reset.
module tb_uart_rx;

    localparam int C   = 12;
    localparam int LAT = 117; // pin fall to valid: 2 sync cycles + E+115

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         v_cyc[$];
    logic [7:0] v_data[$];
    int         fe_cyc[$];
    int         ov_cyc[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
        int         exp_cnt;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid && ready) begin
            v_cyc.push_back(cyc);
            v_data.push_back(data);
        end
        if (frame_err) fe_cyc.push_back(cyc);
        if (overrun)   ov_cyc.push_back(cyc);
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        v_cyc.delete();
        v_data.delete();
        fe_cyc.delete();
        ov_cyc.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int c_start);
        logic [9:0] fr;
        fr      = {stop_bit, b, 1'b0};
        c_start = cyc;
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            repeat (C) tick();
        end
    endtask

    function automatic logic [31:0] vdat(input int i);
        return (v_data.size() > i) ? {24'h0, v_data[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] vcy(input int i);
        return (v_cyc.size() > i) ? v_cyc[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int c0;
        int c1;
        logic [9:0] fr;

        vecs[0] = '{tx: 8'h55, exp_data: 8'h55, exp_cnt: 1, exp_lat: LAT};
        vecs[1] = '{tx: 8'h01, exp_data: 8'h01, exp_cnt: 1, exp_lat: LAT};
        vecs[2] = '{tx: 8'h80, exp_data: 8'h80, exp_cnt: 1, exp_lat: LAT};
        vecs[3] = '{tx: 8'hFE, exp_data: 8'hFE, exp_cnt: 1, exp_lat: LAT};
        vecs[4] = '{tx: 8'h96, exp_data: 8'h96, exp_cnt: 1, exp_lat: LAT};

        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) tick();
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_ferr", {31'h0, frame_err}, 32'h0);
        chk("rst_ovr", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        idle(20);

        for (int i = 0; i < 5; i++) begin
            clear_logs();
            send_frame(vecs[i].tx, 1'b1, c0);
            idle(10);
            chk("vec_cnt", v_cyc.size(), vecs[i].exp_cnt);
            chk("vec_data", vdat(0), {24'h0, vecs[i].exp_data});
            chk("vec_lat", vcy(0) - c0, vecs[i].exp_lat);
            chk("vec_ferr", fe_cyc.size(), 0);
            chk("vec_ovr", ov_cyc.size(), 0);
        end

        // Back-to-back 0x00 then 0xFF: deliveries exactly one frame apart.
        clear_logs();
        send_frame(8'h00, 1'b1, c0);
        send_frame(8'hFF, 1'b1, c1);
        idle(10);
        chk("b2b_cnt", v_cyc.size(), 2);
        chk("b2b_d0", vdat(0), 32'h00);
        chk("b2b_d1", vdat(1), 32'hFF);
        chk("b2b_lat", vcy(0) - c0, LAT);
        chk("b2b_gap", vcy(1) - vcy(0), 120);

        // Four-cycle glitch is rejected; the following frame is clean.
        clear_logs();
        rx = 1'b0;
        repeat (4) tick();
        idle(40);
        chk("glitch_cnt", v_cyc.size(), 0);
        chk("glitch_ferr", fe_cyc.size(), 0);
        send_frame(8'hA5, 1'b1, c0);
        idle(10);
        chk("postglitch_cnt", v_cyc.size(), 1);
        chk("postglitch_data", vdat(0), 32'hA5);
        chk("postglitch_lat", vcy(0) - c0, LAT);

        // Low stop bit, line held low: one framing-error pulse, no delivery.
        clear_logs();
        send_frame(8'h3C, 1'b0, c0);
        rx = 1'b0;
        repeat (50) tick();
        idle(20);
        chk("ferr_cnt", fe_cyc.size(), 1);
        chk("ferr_cyc", (fe_cyc.size() > 0) ? fe_cyc[0] - c0 : -1, LAT);
        chk("ferr_valid_cnt", v_cyc.size(), 0);
        chk("ferr_valid", {31'h0, valid}, 32'h0);
        send_frame(8'h81, 1'b1, c0);
        idle(10);
        chk("postferr_cnt", v_cyc.size(), 1);
        chk("postferr_data", vdat(0), 32'h81);

        // ready low: second byte is dropped with an overrun pulse.
        clear_logs();
        ready = 1'b0;
        send_frame(8'hA5, 1'b1, c0);
        idle(5);
        chk("ovr_valid1", {31'h0, valid}, 32'h1);
        chk("ovr_data1", {24'h0, data}, 32'hA5);
        send_frame(8'h3C, 1'b1, c1);
        idle(5);
        chk("ovr_cnt", ov_cyc.size(), 1);
        chk("ovr_cyc", (ov_cyc.size() > 0) ? ov_cyc[0] - c1 : -1, LAT);
        chk("ovr_data2", {24'h0, data}, 32'hA5);
        chk("ovr_valid2", {31'h0, valid}, 32'h1);
        chk("ovr_noconsume", v_cyc.size(), 0);
        ready = 1'b1;
        chk("ovr_valid_hold", {31'h0, valid}, 32'h1);
        tick();
        chk("ovr_valid_clr", {31'h0, valid}, 32'h0);
        chk("ovr_consumed", vdat(0), 32'hA5);

        // Reset during data bit 4 of 0x0F, released at the stop bit.
        clear_logs();
        fr = {1'b1, 8'h0F, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = fr[k];
            for (int j = 0; j < C; j++) begin
                if (k == 5 && j == 6) rst_n = 1'b0;
                if (k == 9 && j == 0) rst_n = 1'b1;
                tick();
                if (k == 7 && j == 0) begin
                    chk("midrst_valid", {31'h0, valid}, 32'h0);
                    chk("midrst_data", {24'h0, data}, 32'h0);
                end
            end
        end
        idle(130);
        chk("abort_cnt", v_cyc.size(), 0);
        chk("abort_ferr", fe_cyc.size(), 0);
        send_frame(8'hC3, 1'b1, c0);
        idle(10);
        chk("postrst_cnt", v_cyc.size(), 1);
        chk("postrst_data", vdat(0), 32'hC3);
        chk("postrst_lat", vcy(0) - c0, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
